// File: rtl/point_move_sequencer.sv
// point_move_sequencer
//   Initiator for a grid point's xMove/yMove/en/update interface. Takes a
//   target coordinate (1..5 per axis), reads the point's current position and
//   issues clamped moves, each followed by a settle window, until the point
//   reaches the target, the step budget runs out, or the request is aborted.
//
// Parameters
//   MAX_STEP      largest per-axis move magnitude per step (1..3)
//   SETTLE_CYCLES cycles to wait after update falls before sampling pos (>=1)
//   MAX_STEPS     update pulses allowed per request before failing (1..15)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request strobe, sampled only while idle
//   abort             cancel the in-flight request
//   tgt_x, tgt_y      target coordinate
//   pos_x, pos_y      current point position
//   x_move, y_move    3-bit two's complement step to the point
//   move_en           point enable
//   update            one-cycle step strobe to the point
//   busy              high whenever a request is in progress
//   done / err        one-cycle completion / failure pulses
module point_move_sequencer #(
  parameter int MAX_STEP      = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_STEPS     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] tgt_x,
  input  logic [2:0] tgt_y,
  input  logic [2:0] pos_x,
  input  logic [2:0] pos_y,
  output logic [2:0] x_move,
  output logic [2:0] y_move,
  output logic       move_en,
  output logic       update,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CALC   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

  // The settle counter runs 0..SETTLE_CYCLES: the first SETTLE cycle carries
  // the update pulse, the remaining SETTLE_CYCLES cycles are hold time.
  localparam int              SW          = $clog2(SETTLE_CYCLES + 2);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES);
  localparam logic [3:0]      STEP_LIMIT  = 4'(MAX_STEPS);
  localparam logic signed [3:0] STEP_POS  = 4'(MAX_STEP);
  localparam logic signed [3:0] STEP_NEG  = -STEP_POS;

  logic [2:0]        state_q, state_d;
  logic [2:0]        tgt_x_q, tgt_x_d;
  logic [2:0]        tgt_y_q, tgt_y_d;
  logic [3:0]        step_cnt_q, step_cnt_d;
  logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [2:0]        x_move_q, x_move_d;
  logic [2:0]        y_move_q, y_move_d;
  logic              move_en_q, move_en_d;
  logic              update_q, update_d;
  logic signed [3:0] dx, dy;

  function automatic logic [2:0] clamp_step(input logic signed [3:0] d);
    logic signed [3:0] c;
    if (d > STEP_POS)      c = STEP_POS;
    else if (d < STEP_NEG) c = STEP_NEG;
    else                   c = d;
    return c[2:0];
  endfunction

  function automatic logic coord_valid(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd5);
  endfunction

  // Both operands are 1..5 (target) or 0..7 (position), so a 4-bit signed
  // difference never overflows.
  assign dx = $signed({1'b0, tgt_x_q}) - $signed({1'b0, pos_x});
  assign dy = $signed({1'b0, tgt_y_q}) - $signed({1'b0, pos_y});

  always_comb begin
    state_d      = state_q;
    tgt_x_d      = tgt_x_q;
    tgt_y_d      = tgt_y_q;
    step_cnt_d   = step_cnt_q;
    settle_cnt_d = settle_cnt_q;
    x_move_d     = x_move_q;
    y_move_d     = y_move_q;
    move_en_d    = move_en_q;
    update_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tgt_x_d    = tgt_x;
          tgt_y_d    = tgt_y;
          step_cnt_d = 4'd0;
          if (coord_valid(tgt_x) && coord_valid(tgt_y)) state_d = S_CALC;
          else                                          state_d = S_FAIL;
        end
      end
      S_CALC: begin
        if (dx == 4'sd0 && dy == 4'sd0) begin
          state_d   = S_DONE;
          x_move_d  = 3'd0;
          y_move_d  = 3'd0;
          move_en_d = 1'b0;
        end else begin
          state_d   = S_ISSUE;
          x_move_d  = clamp_step(dx);
          y_move_d  = clamp_step(dy);
          move_en_d = 1'b1;
        end
      end
      S_ISSUE: begin
        // update is registered here so it rises one cycle after the moves,
        // giving the point setup time on its posedge update.
        update_d     = 1'b1;
        step_cnt_d   = step_cnt_q + 4'd1;
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = S_CHECK;
        else settle_cnt_d = settle_cnt_q + 1'b1;
      end
      S_CHECK: begin
        if (pos_x == tgt_x_q && pos_y == tgt_y_q) begin
          state_d   = S_DONE;
          x_move_d  = 3'd0;
          y_move_d  = 3'd0;
          move_en_d = 1'b0;
        end else if (step_cnt_q == STEP_LIMIT) begin
          state_d   = S_FAIL;
          x_move_d  = 3'd0;
          y_move_d  = 3'd0;
          move_en_d = 1'b0;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort overrides every transition above but is meaningless when idle,
    // which is what lets a simultaneous start win.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      x_move_d  = 3'd0;
      y_move_d  = 3'd0;
      move_en_d = 1'b0;
      update_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tgt_x_q      <= 3'd0;
      tgt_y_q      <= 3'd0;
      step_cnt_q   <= 4'd0;
      settle_cnt_q <= '0;
      x_move_q     <= 3'd0;
      y_move_q     <= 3'd0;
      move_en_q    <= 1'b0;
      update_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_x_q      <= tgt_x_d;
      tgt_y_q      <= tgt_y_d;
      step_cnt_q   <= step_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      x_move_q     <= x_move_d;
      y_move_q     <= y_move_d;
      move_en_q    <= move_en_d;
      update_q     <= update_d;
    end
  end

  assign x_move  = x_move_q;
  assign y_move  = y_move_q;
  assign move_en = move_en_q;
  assign update  = update_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = (state_q == S_FAIL);

endmodule

// File: tb/tb_point_move_sequencer.sv
// tb_point_move_sequencer
//   Three sequencer instances driving bench-side point registers:
//   instance 0 uses default parameters and is followed cycle by cycle by a
//   transaction-level model; instance 1 uses MAX_STEP=2; instance 2 uses
//   MAX_STEP=1, MAX_STEPS=1. Directed scenarios add hand-computed checks.
module tb_point_move_sequencer;

  localparam int MS[3] = '{3, 2, 1};
  localparam int MX[3] = '{8, 8, 1};
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0] start, abort, busy, done, err, upd, men, load;
  logic [2:0][2:0] tx, ty, px, py, xm, ym, lx, ly;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int updCnt[3], doneCnt[3], errCnt[3], doneCyc[3], errCyc[3], lastXm[3], lastYm[3];

  point_move_sequencer #(.MAX_STEP(MS[0]), .SETTLE_CYCLES(SETTLE), .MAX_STEPS(MX[0])) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .tgt_x(tx[0]), .tgt_y(ty[0]), .pos_x(px[0]), .pos_y(py[0]),
    .x_move(xm[0]), .y_move(ym[0]), .move_en(men[0]), .update(upd[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]));

  point_move_sequencer #(.MAX_STEP(MS[1]), .SETTLE_CYCLES(SETTLE), .MAX_STEPS(MX[1])) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .tgt_x(tx[1]), .tgt_y(ty[1]), .pos_x(px[1]), .pos_y(py[1]),
    .x_move(xm[1]), .y_move(ym[1]), .move_en(men[1]), .update(upd[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]));

  point_move_sequencer #(.MAX_STEP(MS[2]), .SETTLE_CYCLES(SETTLE), .MAX_STEPS(MX[2])) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .tgt_x(tx[2]), .tgt_y(ty[2]), .pos_x(px[2]), .pos_y(py[2]),
    .x_move(xm[2]), .y_move(ym[2]), .move_en(men[2]), .update(upd[2]),
    .busy(busy[2]), .done(done[2]), .err(err[2]));

  // Cycle index: cycle k is the interval following the k-th rising edge.
  always @(posedge clk) cyc++;

  // Bench-side point registers: apply the move on the rising edge of
  // update when enabled, or load a new position on request.
  logic [2:0] updPrev = 3'b000;
  always @(upd or load) begin
    for (int g = 0; g < 3; g++) begin
      if (load[g]) begin
        px[g] = lx[g];
        py[g] = ly[g];
      end else if (upd[g] && !updPrev[g] && men[g]) begin
        px[g] = px[g] + xm[g];
        py[g] = py[g] + ym[g];
      end
    end
    updPrev = upd;
  end

  // Event monitor used by the directed checks: counts strobes and records
  // the cycle and move values at which they were seen.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (upd[g]) begin
        updCnt[g]++;
        lastXm[g] = int'(xm[g]);
        lastYm[g] = int'(ym[g]);
      end
      if (done[g]) begin doneCnt[g]++; doneCyc[g] = cyc; end
      if (err[g])  begin errCnt[g]++;  errCyc[g]  = cyc; end
    end
  end

  task automatic checkOutput(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of instance 0: on an accepted request, the whole
  // expected output trace is derived from target/position arithmetic and
  // queued, one entry per cycle.
  typedef struct {
    bit busy, done, err, upd, en;
    int xm, ym;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  bit   curBusy = 1'b0;

  task automatic pushExp(input bit b, input bit d, input bit e, input bit u,
                         input bit en, input int x, input int y);
    exp_t t;
    t.busy = b; t.done = d; t.err = e; t.upd = u; t.en = en;
    t.xm = x & 7; t.ym = y & 7;
    expq.push_back(t);
  endtask

  function automatic int clampStep(input int d, input int m);
    if (d > m)  return m;
    if (d < -m) return -m;
    return d;
  endfunction

  task automatic buildModel(input int tgx, input int tgy, input int ppx, input int ppy);
    int mx = 0, my = 0, steps = 0, cx = ppx, cy = ppy;
    bit en = 0;
    if (tgx < 1 || tgx > 5 || tgy < 1 || tgy > 5) begin
      pushExp(1, 0, 1, 0, 0, 0, 0);
      return;
    end
    forever begin
      pushExp(1, 0, 0, 0, en, mx, my);
      if (tgx == cx && tgy == cy) begin
        pushExp(1, 1, 0, 0, 0, 0, 0);
        return;
      end
      mx = clampStep(tgx - cx, MS[0]);
      my = clampStep(tgy - cy, MS[0]);
      en = 1;
      pushExp(1, 0, 0, 0, 1, mx, my);
      pushExp(1, 0, 0, 1, 1, mx, my);
      for (int s = 0; s < SETTLE; s++) pushExp(1, 0, 0, 0, 1, mx, my);
      pushExp(1, 0, 0, 0, 1, mx, my);
      steps++;
      cx += mx;
      cy += my;
      if (tgx == cx && tgy == cy) begin
        pushExp(1, 1, 0, 0, 0, 0, 0);
        return;
      end
      if (steps == MX[0]) begin
        pushExp(1, 0, 1, 0, 0, 0, 0);
        return;
      end
    end
  endtask

  // Model stepping on the rising edge, comparison on the falling edge, and
  // an immediate flush whenever reset asserts.
  always @(posedge clk or negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expq.delete();
      curBusy = 1'b0;
    end else if (clk) begin
      if (curBusy && abort[0]) expq.delete();
      else if (!curBusy && start[0])
        buildModel(int'(tx[0]), int'(ty[0]), int'(px[0]), int'(py[0]));
    end else begin
      if (expq.size() > 0) cur = expq.pop_front();
      else begin
        cur.busy = 0; cur.done = 0; cur.err = 0; cur.upd = 0; cur.en = 0;
        cur.xm = 0; cur.ym = 0;
      end
      curBusy = cur.busy;
      checkOutput("model busy",    int'(busy[0]), int'(cur.busy));
      checkOutput("model done",    int'(done[0]), int'(cur.done));
      checkOutput("model err",     int'(err[0]),  int'(cur.err));
      checkOutput("model update",  int'(upd[0]),  int'(cur.upd));
      checkOutput("model move_en", int'(men[0]),  int'(cur.en));
      checkOutput("model x_move",  int'(xm[0]),   cur.xm);
      checkOutput("model y_move",  int'(ym[0]),   cur.ym);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setPoint(input int g, input int x, input int y);
    lx[g] = 3'(x);
    ly[g] = 3'(y);
    load[g] = 1'b1;
    #1 load[g] = 1'b0;
  endtask

  // Pulses start for one cycle; sc returns the cycle in which start was high.
  task automatic applyStimulus(input int g, input int x, input int y, output int sc);
    tx[g] = 3'(x);
    ty[g] = 3'(y);
    start[g] = 1'b1;
    sc = cyc;
    tick(1);
    start[g] = 1'b0;
  endtask

  task automatic waitIdle(input int g, input int bound);
    int n = 0;
    while (busy[g] && n < bound) begin
      tick(1);
      n++;
    end
    checkOutput("idle within bound", int'(busy[g]), 0);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc, u0, d0, e0;
    rst_n = 1'b0;
    start = '0; abort = '0; load = '0;
    tx = '0; ty = '0; lx = '0; ly = '0;
    for (int g = 0; g < 3; g++) setPoint(g, 1, 1);
    #12;
    checkOutput("reset busy",    int'(busy[0]), 0);
    checkOutput("reset done",    int'(done[0]), 0);
    checkOutput("reset err",     int'(err[0]),  0);
    checkOutput("reset update",  int'(upd[0]),  0);
    checkOutput("reset move_en", int'(men[0]),  0);
    checkOutput("reset x_move",  int'(xm[0]),   0);
    checkOutput("reset y_move",  int'(ym[0]),   0);
    checkOutput("reset busy1",   int'(busy[1] | busy[2]), 0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] one step (2,4)->(5,1)");
    setPoint(0, 2, 4);
    u0 = updCnt[0]; d0 = doneCnt[0];
    applyStimulus(0, 5, 1, sc);
    waitIdle(0, 40);
    checkOutput("A updates",  updCnt[0] - u0, 1);
    checkOutput("A x_move",   lastXm[0], 3);
    checkOutput("A y_move",   lastYm[0], 5);
    checkOutput("A done cnt", doneCnt[0] - d0, 1);
    checkOutput("A done lat", doneCyc[0] - sc, 7);
    checkOutput("A pos x",    int'(px[0]), 5);
    checkOutput("A pos y",    int'(py[0]), 1);

    $display("[TB] two steps MAX_STEP=2 (1,1)->(5,5)");
    setPoint(1, 1, 1);
    applyStimulus(1, 5, 5, sc);
    waitIdle(1, 40);
    checkOutput("B updates",  updCnt[1], 2);
    checkOutput("B x_move",   lastXm[1], 2);
    checkOutput("B y_move",   lastYm[1], 2);
    checkOutput("B done cnt", doneCnt[1], 1);
    checkOutput("B done lat", doneCyc[1] - sc, 13);
    checkOutput("B err cnt",  errCnt[1], 0);

    $display("[TB] already at target, start with abort in idle");
    setPoint(0, 3, 3);
    u0 = updCnt[0]; d0 = doneCnt[0];
    abort[0] = 1'b1;
    applyStimulus(0, 3, 3, sc);
    abort[0] = 1'b0;
    waitIdle(0, 20);
    checkOutput("C updates",  updCnt[0] - u0, 0);
    checkOutput("C done cnt", doneCnt[0] - d0, 1);
    checkOutput("C done lat", doneCyc[0] - sc, 2);

    $display("[TB] invalid targets");
    u0 = updCnt[0]; e0 = errCnt[0];
    applyStimulus(0, 0, 3, sc);
    waitIdle(0, 20);
    checkOutput("D0 err lat", errCyc[0] - sc, 1);
    applyStimulus(0, 6, 2, sc);
    waitIdle(0, 20);
    checkOutput("D1 err lat", errCyc[0] - sc, 1);
    checkOutput("D err cnt",  errCnt[0] - e0, 2);
    checkOutput("D updates",  updCnt[0] - u0, 0);

    $display("[TB] step budget MAX_STEPS=1 (1,5)->(5,1)");
    setPoint(2, 1, 5);
    applyStimulus(2, 5, 1, sc);
    waitIdle(2, 40);
    checkOutput("E updates",  updCnt[2], 1);
    checkOutput("E x_move",   lastXm[2], 1);
    checkOutput("E y_move",   lastYm[2], 7);
    checkOutput("E err lat",  errCyc[2] - sc, 7);
    checkOutput("E done cnt", doneCnt[2], 0);

    $display("[TB] abort during settle");
    setPoint(0, 1, 1);
    d0 = doneCnt[0]; e0 = errCnt[0];
    applyStimulus(0, 5, 5, sc);
    tick(3);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    checkOutput("F busy",    int'(busy[0]), 0);
    checkOutput("F x_move",  int'(xm[0]), 0);
    checkOutput("F move_en", int'(men[0]), 0);
    tick(10);
    checkOutput("F no done", doneCnt[0] - d0, 0);
    checkOutput("F no err",  errCnt[0] - e0, 0);
    checkOutput("F pos x",   int'(px[0]), 4);

    $display("[TB] start while busy");
    setPoint(0, 4, 4);
    u0 = updCnt[0]; d0 = doneCnt[0];
    applyStimulus(0, 1, 1, sc);
    tick(1);
    tx[0] = 3'd5; ty[0] = 3'd5;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    waitIdle(0, 40);
    tick(10);
    checkOutput("G updates",  updCnt[0] - u0, 1);
    checkOutput("G done cnt", doneCnt[0] - d0, 1);
    checkOutput("G x_move",   lastXm[0], 5);
    checkOutput("G pos x",    int'(px[0]), 1);

    $display("[TB] reset while update high");
    setPoint(0, 1, 1);
    d0 = doneCnt[0]; e0 = errCnt[0];
    applyStimulus(0, 2, 2, sc);
    tick(2);
    checkOutput("H update pre", int'(upd[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("H update",  int'(upd[0]), 0);
    checkOutput("H busy",    int'(busy[0]), 0);
    checkOutput("H move_en", int'(men[0]), 0);
    #1 rst_n = 1'b1;
    tick(6);
    checkOutput("H no done", doneCnt[0] - d0, 0);
    checkOutput("H no err",  errCnt[0] - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
